// File: rtl/exe_muldiv_ctrl_if.sv
// Pipeline-side and unit-side signals of the EXE-stage mul/div sequencer.
// The controller uses the slave modport. The surrounding pipeline and the
// multiplier/divider use the master modport.
interface exe_muldiv_ctrl_if;
    logic        EXE_valid;
    logic        md_mul;
    logic        md_div;
    logic        md_signed;
    logic [31:0] md_op1;
    logic [31:0] md_op2;
    logic        MEM_allow_in;
    logic        cancel;
    logic        mult_begin;
    logic        mult_end;
    logic [63:0] product;
    logic        div_begin;
    logic        div_signed;
    logic        div_end;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        EXE_over;
    logic [31:0] hi_result;
    logic [31:0] lo_result;
    logic        hi_lo_write;
    logic        md_busy;
    logic        md_timeout;

    modport master (
        output EXE_valid, md_mul, md_div, md_signed, md_op1, md_op2,
               MEM_allow_in, cancel, mult_end, product, div_end,
               quotient, remainder,
        input  mult_begin, div_begin, div_signed, EXE_over, hi_result,
               lo_result, hi_lo_write, md_busy, md_timeout
    );

    modport slave (
        input  EXE_valid, md_mul, md_div, md_signed, md_op1, md_op2,
               MEM_allow_in, cancel, mult_end, product, div_end,
               quotient, remainder,
        output mult_begin, div_begin, div_signed, EXE_over, hi_result,
               lo_result, hi_lo_write, md_busy, md_timeout
    );
endinterface

// File: rtl/exe_muldiv_ctrl.sv
// EXE-stage sequencer for the iterative multiplier and divider.
// It launches a unit and holds the request until the unit reports done.
// It captures {HI,LO}, stalls the pipeline until MEM accepts the result,
// and handles flush, divide-by-zero and a watchdog.
//
//  state | meaning
//  IDLE  | no operation in flight
//  BUSY  | a unit is running; begin held from latched op type
//  DONE  | result held, waiting for MEM to accept
module exe_muldiv_ctrl #(
    parameter int unsigned TIMEOUT = 40
) (
    input logic              clk,
    input logic              reset,
    exe_muldiv_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Last BUSY cycle before the watchdog fires (counter starts at 0).
    localparam logic [5:0] LP_WDOG_LAST = 6'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_is_mul;
    logic        r_signed;
    logic [63:0] r_result;
    logic [5:0]  r_wdog;
    logic        r_timeout;

    logic        w_op;
    logic        w_div_zero;
    logic        w_latch;
    logic        w_load;
    logic [63:0] w_load_val;
    logic        w_wdog_expire;
    logic        w_mult_begin;
    logic        w_div_begin;
    logic        w_div_signed;

    assign w_op       = bus.md_mul | bus.md_div;
    assign w_div_zero = (bus.md_op2 == 32'd0);

    // Next-state, result-load and unit-request decode.
    always_comb begin
        w_next_state  = r_state;
        w_latch       = 1'b0;
        w_load        = 1'b0;
        w_load_val    = r_result;
        w_wdog_expire = 1'b0;
        w_mult_begin  = 1'b0;
        w_div_begin   = 1'b0;
        w_div_signed  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_mult_begin = bus.EXE_valid & bus.md_mul & ~bus.cancel;
                w_div_begin  = bus.EXE_valid & bus.md_div & ~bus.cancel & ~w_div_zero;
                w_div_signed = w_div_begin & bus.md_signed;
                if (bus.EXE_valid & bus.md_div & w_div_zero & ~bus.cancel) begin
                    // Zero divisor: the divider is never started.
                    w_next_state = ST_DONE;
                    w_load       = 1'b1;
                    w_load_val   = {bus.md_op1, 32'hFFFF_FFFF};
                end else if (bus.EXE_valid & w_op & ~bus.cancel) begin
                    w_next_state = ST_BUSY;
                    w_latch      = 1'b1;
                end
            end
            ST_BUSY: begin
                w_mult_begin = r_is_mul & ~bus.cancel;
                w_div_begin  = ~r_is_mul & ~bus.cancel;
                w_div_signed = w_div_begin & r_signed;
                if (bus.cancel) begin
                    w_next_state = ST_IDLE;
                end else if (r_is_mul & bus.mult_end) begin
                    w_next_state = ST_DONE;
                    w_load       = 1'b1;
                    w_load_val   = bus.product;
                end else if (~r_is_mul & bus.div_end) begin
                    w_next_state = ST_DONE;
                    w_load       = 1'b1;
                    w_load_val   = {bus.remainder, bus.quotient};
                end else if (r_wdog == LP_WDOG_LAST) begin
                    w_next_state  = ST_IDLE;
                    w_wdog_expire = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.cancel | bus.MEM_allow_in) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latched op type, result register, watchdog counter and sticky flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_mul  <= 1'b0;
            r_signed  <= 1'b0;
            r_result  <= 64'd0;
            r_wdog    <= 6'd0;
            r_timeout <= 1'b0;
        end else begin
            if (w_latch) begin
                r_is_mul <= bus.md_mul;
                r_signed <= bus.md_signed;
            end
            if (w_load) begin
                r_result <= w_load_val;
            end
            if (w_latch) begin
                r_wdog <= 6'd0;
            end else if (r_state == ST_BUSY) begin
                r_wdog <= r_wdog + 6'd1;
            end
            if (w_wdog_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign bus.mult_begin  = w_mult_begin;
    assign bus.div_begin   = w_div_begin;
    assign bus.div_signed  = w_div_signed;
    assign bus.EXE_over    = bus.EXE_valid & ~bus.cancel & (~w_op | (r_state == ST_DONE));
    assign bus.hi_result   = r_result[63:32];
    assign bus.lo_result   = r_result[31:0];
    assign bus.hi_lo_write = (r_state == ST_DONE);
    assign bus.md_busy     = (r_state == ST_BUSY);
    assign bus.md_timeout  = r_timeout;

endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// Directed bench for exe_muldiv_ctrl. The bench plays the pipeline and both
// arithmetic units. Expected {HI,LO} values are queued at launch and popped
// when the controller presents a completed result.
module tb_exe_muldiv_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    logic [63:0] sb_q[$];
    logic [63:0] held;

    exe_muldiv_ctrl_if mif ();

    exe_muldiv_ctrl #(.TIMEOUT(40)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic sb_check(input string tag);
        logic [63:0] e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s observed=result expected=empty scoreboard entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk(tag, {mif.hi_result, mif.lo_result}, e);
        end
    endtask

    task automatic idle_inputs();
        mif.EXE_valid    = 1'b0;
        mif.md_mul       = 1'b0;
        mif.md_div       = 1'b0;
        mif.md_signed    = 1'b0;
        mif.md_op1       = 32'd0;
        mif.md_op2       = 32'd0;
        mif.cancel       = 1'b0;
        mif.mult_end     = 1'b0;
        mif.div_end      = 1'b0;
        mif.product      = 64'd0;
        mif.quotient     = 32'd0;
        mif.remainder    = 32'd0;
    endtask

    task automatic issue(input logic mul, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        mif.EXE_valid = 1'b1;
        mif.md_mul    = mul;
        mif.md_div    = ~mul;
        mif.md_signed = sgn;
        mif.md_op1    = a;
        mif.md_op2    = b;
    endtask

    initial begin
        logic signed [63:0] sprod;
        int signed          sq;
        int signed          sr;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        idle_inputs();
        mif.MEM_allow_in = 1'b1;

        // Reset: ADD in flight gets EXE_over, everything else low.
        tick(); tick();
        mif.EXE_valid = 1'b1;
        settle();
        chk("rst_exe_over_add", 64'(mif.EXE_over), 64'd1);
        tick();
        chk("rst_busy", 64'(mif.md_busy), 64'd0);
        chk("rst_hlw", 64'(mif.hi_lo_write), 64'd0);
        chk("rst_hilo", {mif.hi_result, mif.lo_result}, 64'd0);
        chk("rst_timeout", 64'(mif.md_timeout), 64'd0);
        chk("rst_begins", {62'd0, mif.mult_begin, mif.div_begin}, 64'd0);
        reset = 1'b0;
        mif.EXE_valid = 1'b0;
        tick();

        // MULT signed -3 * 7, end 32 cycles after launch; a stray div_end is ignored.
        issue(1'b1, 1'b1, 32'hFFFF_FFFD, 32'd7);
        sprod = 64'($signed(mif.md_op1)) * 64'($signed(mif.md_op2));
        sb_q.push_back(sprod);
        settle();
        chk("mul_begin_t0", 64'(mif.mult_begin), 64'd1);
        chk("mul_divbegin_t0", 64'(mif.div_begin), 64'd0);
        chk("mul_over_t0", 64'(mif.EXE_over), 64'd0);
        for (int i = 1; i <= 32; i++) begin
            tick();
            mif.div_end = (i == 5);
            mif.mult_end = (i == 32);
            mif.product = (i == 32) ? sprod : 64'hDEAD_BEEF_0BAD_F00D;
            settle();
            if (i == 1) chk("mul_busy_t1", 64'(mif.md_busy), 64'd1);
            if (i == 6) chk("mul_ignore_div_end", 64'(mif.md_busy), 64'd1);
            if (i == 31) chk("mul_begin_held", 64'(mif.mult_begin), 64'd1);
            if (i == 32) chk("mul_over_at_end", 64'(mif.EXE_over), 64'd0);
        end
        tick();
        mif.mult_end = 1'b0;
        mif.product  = 64'h1234_5678_9ABC_DEF0;
        settle();
        chk("mul_over_done", 64'(mif.EXE_over), 64'd1);
        chk("mul_hlw", 64'(mif.hi_lo_write), 64'd1);
        sb_check("mul_result");
        tick();
        mif.EXE_valid = 1'b0;
        settle();
        chk("mul_idle_after", {62'd0, mif.md_busy, mif.hi_lo_write}, 64'd0);

        // DIVU 100/7, end after 33 cycles, MEM stalls for 3 cycles.
        tick();
        issue(1'b0, 1'b0, 32'd100, 32'd7);
        sb_q.push_back({32'd100 % 32'd7, 32'd100 / 32'd7});
        settle();
        chk("divu_begin_t0", 64'(mif.div_begin), 64'd1);
        chk("divu_signed_t0", 64'(mif.div_signed), 64'd0);
        for (int i = 1; i <= 33; i++) begin
            tick();
            mif.div_end   = (i == 33);
            mif.quotient  = 32'd100 / 32'd7;
            mif.remainder = 32'd100 % 32'd7;
        end
        mif.MEM_allow_in = 1'b0;
        tick();
        mif.div_end   = 1'b0;
        mif.quotient  = 32'hAAAA_AAAA;
        mif.remainder = 32'h5555_5555;
        settle();
        held = {mif.hi_result, mif.lo_result};
        sb_check("divu_result");
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            settle();
            chk("divu_stall_over", 64'(mif.EXE_over), 64'd1);
            chk("divu_stall_hilo", {mif.hi_result, mif.lo_result}, {32'd2, 32'd14});
        end
        tick();
        mif.MEM_allow_in = 1'b1;
        tick();
        mif.EXE_valid = 1'b0;
        settle();
        chk("divu_idle_after", {62'd0, mif.md_busy, mif.hi_lo_write}, 64'd0);

        // DIV by zero: divider never started, DONE at T0+1.
        tick();
        issue(1'b0, 1'b1, 32'd5, 32'd0);
        sb_q.push_back({32'd5, 32'hFFFF_FFFF});
        settle();
        chk("dz_divbegin_t0", 64'(mif.div_begin), 64'd0);
        chk("dz_over_t0", 64'(mif.EXE_over), 64'd0);
        tick();
        settle();
        chk("dz_over_t1", 64'(mif.EXE_over), 64'd1);
        chk("dz_divbegin_t1", 64'(mif.div_begin), 64'd0);
        chk("dz_hlw", 64'(mif.hi_lo_write), 64'd1);
        sb_check("dz_result");
        held = {mif.hi_result, mif.lo_result};
        tick();
        mif.EXE_valid = 1'b0;

        // Cancel 10 cycles into a MULT, then a signed DIV runs normally.
        tick();
        issue(1'b1, 1'b0, 32'd9, 32'd9);
        for (int i = 1; i <= 10; i++) tick();
        mif.cancel = 1'b1;
        settle();
        chk("cx_mult_begin_low", 64'(mif.mult_begin), 64'd0);
        chk("cx_over_low", 64'(mif.EXE_over), 64'd0);
        tick();
        mif.cancel = 1'b0;
        mif.EXE_valid = 1'b0;
        settle();
        chk("cx_idle", {62'd0, mif.md_busy, mif.hi_lo_write}, 64'd0);
        chk("cx_result_kept", {mif.hi_result, mif.lo_result}, held);
        tick();
        issue(1'b0, 1'b1, 32'hFFFF_FFEC, 32'd3);
        sq = $signed(mif.md_op1) / $signed(mif.md_op2);
        sr = $signed(mif.md_op1) % $signed(mif.md_op2);
        sb_q.push_back({32'(sr), 32'(sq)});
        settle();
        chk("cx_div_begin", {62'd0, mif.div_begin, mif.div_signed}, 64'd3);
        for (int i = 1; i <= 5; i++) begin
            tick();
            mif.div_end   = (i == 5);
            mif.quotient  = 32'(sq);
            mif.remainder = 32'(sr);
        end
        tick();
        mif.div_end = 1'b0;
        settle();
        sb_check("cx_div_result");
        held = {mif.hi_result, mif.lo_result};
        tick();
        mif.EXE_valid = 1'b0;

        // cancel and mult_end in the same cycle: cancel wins, nothing captured.
        tick();
        issue(1'b1, 1'b0, 32'd3, 32'd4);
        for (int i = 1; i <= 3; i++) tick();
        mif.mult_end = 1'b1;
        mif.product  = 64'd12;
        mif.cancel   = 1'b1;
        tick();
        mif.mult_end  = 1'b0;
        mif.cancel    = 1'b0;
        mif.EXE_valid = 1'b0;
        settle();
        chk("ce_no_done", {62'd0, mif.md_busy, mif.hi_lo_write}, 64'd0);
        chk("ce_result_kept", {mif.hi_result, mif.lo_result}, held);

        // Watchdog: unit never ends; fires after 40 BUSY cycles.
        tick();
        issue(1'b1, 1'b1, 32'd1, 32'd1);
        for (int i = 1; i <= 40; i++) tick();
        settle();
        chk("wd_busy_40", 64'(mif.md_busy), 64'd1);
        chk("wd_flag_40", 64'(mif.md_timeout), 64'd0);
        mif.EXE_valid = 1'b0;
        tick();
        settle();
        chk("wd_flag_set", 64'(mif.md_timeout), 64'd1);
        chk("wd_idle", 64'(mif.md_busy), 64'd0);
        chk("wd_begin_low", 64'(mif.mult_begin), 64'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("wd_flag_sticky", 64'(mif.md_timeout), 64'd1);

        // Reset mid-BUSY with an ADD in EXE.
        issue(1'b0, 1'b0, 32'd50, 32'd9);
        for (int i = 1; i <= 3; i++) tick();
        reset = 1'b1;
        mif.md_div = 1'b0;
        mif.md_mul = 1'b0;
        settle();
        chk("mr_add_over", 64'(mif.EXE_over), 64'd1);
        tick();
        reset = 1'b0;
        settle();
        chk("mr_busy", 64'(mif.md_busy), 64'd0);
        chk("mr_timeout", 64'(mif.md_timeout), 64'd0);
        chk("mr_hilo", {mif.hi_result, mif.lo_result}, 64'd0);
        chk("mr_begins", {61'd0, mif.mult_begin, mif.div_begin, mif.hi_lo_write}, 64'd0);
        chk("mr_add_over_after", 64'(mif.EXE_over), 64'd1);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
